// File: rtl/lc3b_types.sv
// Shared LC-3b types: the 16-bit machine word and the memory responder FSM states.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } lc3b_mem_state;

endpackage

// File: rtl/mem_array.sv
// Word storage: byte-masked synchronous write, combinational read at the same index.
// No reset; contents survive reset_n so an aborted write leaves old data intact.
module mem_array
   import lc3b_types::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [1:0]            wmask,
   input  logic [ADDR_WIDTH-1:0] index,
   input  lc3b_word              wdata,
   output lc3b_word              rdata
);

   lc3b_word words [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (we) begin
         if (wmask[0]) words[index][7:0]  <= wdata[7:0];
         if (wmask[1]) words[index][15:8] <= wdata[15:8];
      end
   end

   assign rdata = words[index];

endmodule

// File: rtl/mem_port_responder.sv
// Two-port memory responder: one access in flight, round-robin between ports A and B.
// Response pulses LATENCY+1 cycles after acceptance; requests wait while BUSY/RESP.
module mem_port_responder
   import lc3b_types::*;
#(
   parameter int LATENCY    = 2,
   parameter int ADDR_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        read_a,
   input  logic        write_a,
   input  logic [15:0] address_a,
   input  logic [1:0]  wmask_a,
   input  lc3b_word    wdata_a,
   output logic        resp_a,
   output lc3b_word    rdata_a,
   input  logic        read_b,
   input  logic        write_b,
   input  logic [15:0] address_b,
   input  logic [1:0]  wmask_b,
   input  lc3b_word    wdata_b,
   output logic        resp_b,
   output lc3b_word    rdata_b
);

   lc3b_mem_state         state;
   logic [3:0]            count;
   logic                  srv_b;
   logic                  op_write;
   logic                  last_b;
   logic [ADDR_WIDTH-1:0] idx;
   logic [1:0]            mask;
   lc3b_word              wdat;

   logic     req_a;
   logic     req_b;
   logic     grant_b;
   logic     commit;
   lc3b_word mem_rdata;
   logic     unused_addr_bits;

   assign req_a   = read_a | write_a;
   assign req_b   = read_b | write_b;
   // On a tie, serve whichever port did not win last time.
   assign grant_b = req_b & (~req_a | ~last_b);
   assign commit  = (state == BUSY) && (count == 4'd0);

   // Byte offset and bits above the word index alias onto the same word.
   assign unused_addr_bits = ^{address_a, address_b};

   mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
      .clk   (clk),
      .we    (commit & op_write),
      .wmask (mask),
      .index (idx),
      .wdata (wdat),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         count    <= 4'd0;
         srv_b    <= 1'b0;
         op_write <= 1'b0;
         last_b   <= 1'b0;
         idx      <= '0;
         mask     <= 2'b00;
         wdat     <= '0;
         resp_a   <= 1'b0;
         resp_b   <= 1'b0;
         rdata_a  <= '0;
         rdata_b  <= '0;
      end else begin
         resp_a  <= 1'b0;
         resp_b  <= 1'b0;
         rdata_a <= '0;
         rdata_b <= '0;
         unique case (state)
            IDLE: begin
               if (req_a | req_b) begin
                  state  <= BUSY;
                  count  <= 4'(LATENCY - 1);
                  srv_b  <= grant_b;
                  last_b <= grant_b;
                  if (grant_b) begin
                     op_write <= write_b;
                     idx      <= address_b[ADDR_WIDTH:1];
                     mask     <= wmask_b;
                     wdat     <= wdata_b;
                  end else begin
                     op_write <= write_a;
                     idx      <= address_a[ADDR_WIDTH:1];
                     mask     <= wmask_a;
                     wdat     <= wdata_a;
                  end
               end
            end
            BUSY: begin
               if (count == 4'd0) begin
                  state <= RESP;
                  // A combined read+write is a write and returns zero data.
                  if (srv_b) begin
                     resp_b  <= 1'b1;
                     rdata_b <= op_write ? '0 : mem_rdata;
                  end else begin
                     resp_a  <= 1'b1;
                     rdata_a <= op_write ? '0 : mem_rdata;
                  end
               end else begin
                  count <= count - 4'd1;
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_responder.sv
// Random and directed stimulus against a transaction-level model of the two-port responder.
module tb_mem_port_responder;

   localparam int LAT   = 2;
   localparam int AW    = 8;
   localparam int WORDS = 2**AW;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        read_a = 1'b0, write_a = 1'b0, read_b = 1'b0, write_b = 1'b0;
   logic [15:0] address_a = '0, address_b = '0, wdata_a = '0, wdata_b = '0;
   logic [1:0]  wmask_a = '0, wmask_b = '0;
   logic        resp_a, resp_b;
   logic [15:0] rdata_a, rdata_b;

   mem_port_responder #(.LATENCY(LAT), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .read_a(read_a), .write_a(write_a), .address_a(address_a),
      .wmask_a(wmask_a), .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
      .read_b(read_b), .write_b(write_b), .address_b(address_b),
      .wmask_b(wmask_b), .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Transaction-level model: storage image, when the responder is next free, one pending op.
   logic [15:0] mem_m [WORDS];
   bit          known [WORDS];
   int          e = 0;
   int          next_free = 0;
   bit          last_b = 1'b0;
   bit          p_vld = 1'b0, p_b, p_wr, p_known;
   int          p_edge, p_idx;
   logic [1:0]  p_mask;
   logic [15:0] p_wd, p_data;
   bit          act_a = 0, act_b = 0, acc_a = 0, acc_b = 0, seen_a = 0, seen_b = 0;
   logic [15:0] got_a, got_b;
   int          resp_e_a, resp_e_b, acc_e;

   task automatic model_reset();
      p_vld = 0; last_b = 0; next_free = 0;
      act_a = 0; act_b = 0; acc_a = 0; acc_b = 0;
   endtask

   task automatic model_edge();
      bit ra, rb, pick_b;
      e++;
      if (!reset_n) return;
      if (p_vld && p_edge == e) begin
         if (p_wr) begin
            if (p_mask[0]) mem_m[p_idx][7:0]  = p_wd[7:0];
            if (p_mask[1]) mem_m[p_idx][15:8] = p_wd[15:8];
            if (p_mask == 2'b11) known[p_idx] = 1'b1;
            p_data = 16'h0000; p_known = 1'b1;
         end else begin
            p_data = mem_m[p_idx]; p_known = known[p_idx];
         end
      end
      ra = read_a | write_a;
      rb = read_b | write_b;
      if (e >= next_free && (ra || rb)) begin
         pick_b    = rb && (!ra || !last_b);
         last_b    = pick_b;
         p_vld     = 1'b1;
         p_b       = pick_b;
         p_edge    = e + LAT;
         next_free = e + LAT + 2;
         acc_e     = e;
         if (pick_b) begin
            p_wr = write_b; p_idx = int'(address_b[15:1]) % WORDS;
            p_mask = wmask_b; p_wd = wdata_b; acc_b = 1'b1;
         end else begin
            p_wr = write_a; p_idx = int'(address_a[15:1]) % WORDS;
            p_mask = wmask_a; p_wd = wdata_a; acc_a = 1'b1;
         end
      end
   endtask

   task automatic check_outputs();
      bit wa, wb;
      wa = p_vld && p_edge == e && !p_b;
      wb = p_vld && p_edge == e && p_b;
      check("resp_a", 32'(resp_a), 32'(wa));
      check("resp_b", 32'(resp_b), 32'(wb));
      if (!wa) check("rdata_a_idle", 32'(rdata_a), 32'h0);
      else if (p_known) check("rdata_a", 32'(rdata_a), 32'(p_data));
      if (!wb) check("rdata_b_idle", 32'(rdata_b), 32'h0);
      else if (p_known) check("rdata_b", 32'(rdata_b), 32'(p_data));
      if (wa) begin seen_a = 1; got_a = rdata_a; resp_e_a = e; act_a = 0; acc_a = 0; end
      if (wb) begin seen_b = 1; got_b = rdata_b; resp_e_b = e; act_b = 0; acc_b = 0; end
      if (wa || wb) p_vld = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic set_port(input bit b, input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [1:0] m, input logic [15:0] wd);
      if (b) begin read_b = rd; write_b = wr; address_b = addr; wmask_b = m; wdata_b = wd; end
      else   begin read_a = rd; write_a = wr; address_a = addr; wmask_a = m; wdata_a = wd; end
   endtask

   task automatic txn(input bit b, input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [1:0] m, input logic [15:0] wd, output logic [15:0] data);
      set_port(b, rd, wr, addr, m, wd);
      if (b) seen_b = 0; else seen_a = 0;
      for (int i = 0; i < 40 && !(b ? seen_b : seen_a); i++) step();
      if (!(b ? seen_b : seen_a)) check(b ? "timeout_b" : "timeout_a", 32'd0, 32'd1);
      data = b ? got_b : got_a;
      set_port(b, 1'b0, 1'b0, addr, m, wd);
   endtask

   task automatic rand_drive(input bit b);
      int op;
      if (!(b ? act_b : act_a)) begin
         if ($urandom_range(1, 0) == 1) begin
            op = $urandom_range(2, 0);
            set_port(b, op != 1, op != 0, 16'($urandom), 2'($urandom), 16'($urandom));
            if (b) act_b = 1; else act_a = 1;
         end else begin
            set_port(b, 1'b0, 1'b0, 16'($urandom), 2'($urandom), 16'($urandom));
         end
      end else if ((b ? acc_b : acc_a) && $urandom_range(3, 0) == 0) begin
         // Disturb an already-accepted request: drop it or change its fields.
         set_port(b, 1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), 16'($urandom));
      end
   endtask

   logic [15:0] d, prior;
   int          q_e[$];
   bit          q_b[$];

   initial begin
      repeat (3) @(negedge clk);
      check("rst_resp_a", 32'(resp_a), 32'h0);
      check("rst_resp_b", 32'(resp_b), 32'h0);
      check("rst_rdata_a", 32'(rdata_a), 32'h0);
      check("rst_rdata_b", 32'(rdata_b), 32'h0);
      model_reset();
      reset_n = 1'b1;

      // First tie after reset goes to B, A follows after the idle gap.
      set_port(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 16'h0);
      set_port(1'b1, 1'b1, 1'b0, 16'h0002, 2'b00, 16'h0);
      seen_a = 0; seen_b = 0;
      for (int i = 0; i < 40 && !(seen_a && seen_b); i++) begin
         step();
         if (seen_a) set_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
         if (seen_b) set_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      end
      check("tie_seen", 32'(seen_a && seen_b), 32'h1);
      check("tie_b_first", 32'(resp_e_b < resp_e_a), 32'h1);
      check("tie_gap", 32'(resp_e_a - resp_e_b), 32'(LAT + 2));

      for (int w = 0; w < WORDS; w++)
         txn(1'b0, 1'b0, 1'b1, 16'(w * 2), 2'b11, 16'($urandom), d);

      txn(1'b1, 1'b0, 1'b1, 16'h0010, 2'b11, 16'hBEEF, d);
      check("beef_lat", 32'(resp_e_b - acc_e), 32'(LAT));
      txn(1'b0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0, d);
      check("beef_read", 32'(d), 32'hBEEF);

      txn(1'b0, 1'b0, 1'b1, 16'h0020, 2'b11, 16'h1234, d);
      txn(1'b1, 1'b0, 1'b1, 16'h0020, 2'b10, 16'hABCD, d);
      txn(1'b0, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0, d);
      check("bytemask", 32'(d), 32'hAB34);

      txn(1'b1, 1'b0, 1'b1, 16'h0202, 2'b11, 16'h5555, d);
      txn(1'b0, 1'b1, 1'b0, 16'h0002, 2'b00, 16'h0, d);
      check("alias_even", 32'(d), 32'h5555);
      txn(1'b1, 1'b1, 1'b0, 16'h0003, 2'b00, 16'h0, d);
      check("alias_odd", 32'(d), 32'h5555);

      // Reset lands in the last BUSY cycle of a write: nothing commits, no response.
      txn(1'b0, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0, prior);
      set_port(1'b0, 1'b0, 1'b1, 16'h0040, 2'b11, 16'h7777);
      seen_a = 0; acc_a = 0;
      for (int i = 0; i < 10 && !acc_a; i++) step();
      check("abort_accepted", 32'(acc_a), 32'h1);
      step();
      reset_n = 1'b0;
      model_reset();
      #1;
      check("abort_resp_a", 32'(resp_a), 32'h0);
      check("abort_rdata_a", 32'(rdata_a), 32'h0);
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      step();
      step();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("abort_no_resp", 32'(seen_a), 32'h0);
      txn(1'b0, 1'b1, 1'b0, 16'h0040, 2'b00, 16'h0, d);
      check("abort_kept", 32'(d), 32'(prior));

      // Both ports held reading: grants must alternate.
      set_port(1'b0, 1'b1, 1'b0, 16'h0010, 2'b00, 16'h0);
      set_port(1'b1, 1'b1, 1'b0, 16'h0020, 2'b00, 16'h0);
      seen_a = 0; seen_b = 0;
      for (int i = 0; i < 100 && q_b.size() < 6; i++) begin
         step();
         if (seen_a) begin q_b.push_back(1'b0); seen_a = 0; end
         if (seen_b) begin q_b.push_back(1'b1); seen_b = 0; end
      end
      check("alt_count", 32'(q_b.size()), 32'd6);
      for (int i = 1; i < q_b.size(); i++)
         check("alt_order", 32'(q_b[i] != q_b[i-1]), 32'h1);
      set_port(1'b1, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);

      // Port A alone held reading: one response every LAT+2 cycles.
      for (int i = 0; i < 12; i++) step();
      seen_a = 0;
      for (int i = 0; i < 100 && q_e.size() < 5; i++) begin
         step();
         if (seen_a) begin q_e.push_back(resp_e_a); seen_a = 0; end
      end
      check("b2b_count", 32'(q_e.size()), 32'd5);
      for (int i = 1; i < q_e.size(); i++)
         check("b2b_gap", 32'(q_e[i] - q_e[i-1]), 32'(LAT + 2));
      set_port(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0);
      for (int i = 0; i < 6; i++) step();
      act_a = 0; act_b = 0; acc_a = 0; acc_b = 0;

      for (int i = 0; i < 3000; i++) begin
         rand_drive(1'b0);
         rand_drive(1'b1);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_responder.md
MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, busy cycles between request acceptance and response; legal range 1..15.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, word-index bits of internal storage (2^ADDR_WIDTH 16-bit words).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 read_a, write_a  input  1 each  port A read/write request, held by initiator until resp_a.
REQ-006 address_a  input  16  port A byte address; wmask_a input 2, byte enables; wdata_a input 16, write data.
REQ-007 resp_a  output  1  port A completion pulse; rdata_a output 16, read data, valid only while resp_a=1.
REQ-008 read_b, write_b, address_b, wmask_b, wdata_b, resp_b, rdata_b SHALL mirror REQ-005..007 for port B.

Function
REQ-009 Word index SHALL be address[ADDR_WIDTH:1]; address[0] and bits above ADDR_WIDTH ignored (aliasing wrap).
REQ-010 Single storage array; one access in flight at a time; FSM states IDLE, BUSY, RESP.
REQ-011 IDLE: if any port requests at a rising edge, accept one, latch port id, op, word index, wmask, wdata; go to BUSY with counter = LATENCY-1.
REQ-012 Arbitration when both ports request in IDLE: round-robin, the port not served last wins; after reset, port B wins the first tie.
REQ-013 BUSY: counter decrements each cycle; at counter=0, next edge enters RESP, commits write or captures read data.
REQ-014 Resp for a request accepted at edge k SHALL be high exactly during cycle k+LATENCY+1, one cycle, only on the served port.
REQ-015 Write SHALL update byte [7:0] iff wmask[0], byte [15:8] iff wmask[1]; wmask=00 completes with resp and no change.
REQ-016 read and write both asserted on one port SHALL be treated as a write; rdata returned 0 for that response.
REQ-017 Read SHALL return array contents including any write committed at an earlier edge (no stale data).
REQ-018 RESP SHALL accept no request; next edge returns to IDLE, so one idle gap separates back-to-back accesses.
REQ-019 Request deasserted while BUSY: operation still completes, write still commits, resp still pulsed.
REQ-020 Inputs changed after acceptance SHALL have no effect on the in-flight operation.
REQ-021 rdata_x SHALL be 0 whenever resp_x=0.

Reset
REQ-022 reset_n=0 SHALL immediately force IDLE, resp_a=resp_b=0, rdata_a=rdata_b=0, counter=0, round-robin pointer=A-last-served.
REQ-023 Reset mid-BUSY SHALL abort: no resp, no write commit; storage array contents unaffected by reset.
REQ-024 First acceptance possible at first rising edge after reset_n deasserts.

Structure
REQ-025 Shared package lc3b_types SHALL supply lc3b_word and a new enum lc3b_mem_state (IDLE, BUSY, RESP).
REQ-026 Storage SHALL be a sub-module mem_array: synchronous byte-masked write, combinational read, no reset.
REQ-027 FSM, arbitration, latch registers, counter reside in mem_port_responder.

Verification
REQ-028 Port B write 0xBEEF, wmask 11, addr 0x0010, LATENCY=2 -> resp_b high exactly cycle k+3; then port A read 0x0010 -> rdata_a=0xBEEF with resp_a.
REQ-029 Byte mask: write 0x1234 mask 11 to 0x0020, then 0xABCD mask 10 -> read returns 0xAB34.
REQ-030 Both ports read in same cycle after reset -> B served first, A resp follows after gap; repeated ties alternate A, B.
REQ-031 Alias: write 0x5555 to 0x0202 (ADDR_WIDTH=8) -> read 0x0002 and 0x0003 both return 0x5555.
REQ-032 reset_n pulsed low during BUSY of write 0x7777 to 0x0040 -> no resp, later read 0x0040 returns prior value.
REQ-033 Back-to-back port A reads held high continuously -> one resp per LATENCY+2 cycles, never two consecutive resp cycles.
